fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder buffer for the 64-point R2^2 SDF FFT pipeline. Sits after
//  the last SDF stage. Accepts the FFT's bit-reversed-order sample stream.
//  Re-emits each complete frame in natural bin order (0..N-1) as one
//  contiguous burst, using a ping-pong pair of N-entry complex buffers.
// PARAMETERS
//  WIDTH  16  bits per real/imag component
//  LOG_N  6   log2 of FFT length
//  N      64  FFT length (2**LOG_N); frame size in samples
// PORTS
//  clock     in   1      master clock, all logic on rising edge
//  reset     in   1      synchronous, active-high reset
//  idata_en  in   1      input sample valid (FFT odata_en)
//  idata_r   in   WIDTH  input real, bit-reversed bin order
//  idata_i   in   WIDTH  input imag, bit-reversed bin order
//  odata_en  out  1      output sample valid
//  odata_r   out  WIDTH  output real, natural bin order
//  odata_i   out  WIDTH  output imag, natural bin order
//  odata_idx out  LOG_N  bin index of current output sample
// BEHAVIOUR
//  Reset (sync, active-high, 1 edge):
//   - odata_en=0, odata_r/odata_i/odata_idx=0.
//   - Write count=0, write bank=0, reader IDLE, no bank pending.
//   - Buffer contents are not cleared.
//   - A partial input frame or an in-progress read-out is discarded.
//  Write side:
//   - Each edge with idata_en=1 stores the sample at bank[wbank][bitrev(wcnt)].
//   - wcnt then increments mod N. Gaps in idata_en are allowed; only
//     accepted samples count.
//   - When the sample with wcnt=N-1 is accepted (edge E):
//     * wbank is marked full.
//     * wbank toggles.
//     * wcnt wraps to 0.
//  Reader FSM, states IDLE / READ:
//   - IDLE: on a full-bank event, latch rbank, set raddr=0, go to READ.
//     The transition happens at edge E+1.
//   - READ: raddr increments by 1 every cycle (no stalls).
//     After raddr=N-1 is issued: if another bank became full, restart READ
//     on that bank; otherwise go to IDLE.
//   - Buffer read is registered. odata_* are registered, one edge after
//     address issue.
//  Latency and throughput:
//   - First odata_en=1 (bin 0) is registered at edge E+2.
//   - odata_en then stays high for exactly N cycles, bins 0..N-1 in order.
//   - odata_idx equals the bin number.
//   - Back-to-back input frames (idata_en held high) produce a continuous
//     odata_en with no gap between frames.
//  Data rules:
//   - Samples pass through bit-exact; no scaling or rounding.
//   - odata_r/odata_i/odata_idx are forced to 0 whenever odata_en=0.
//  Boundary conditions:
//   - Reader finishes a bank at least 1 cycle before the writer can
//     reuse it, so overflow cannot occur and no backpressure exists.
//   - Full-bank event and end-of-READ in the same cycle: the reader goes
//     directly to READ on the new bank with no idle cycle.
//   - A partial frame (<N samples) is held indefinitely until completed.
//     It is never emitted partially.
// TESTING
//  1. One frame, sample k = {r=bitrev(k), i=k}, k=0..63 -> 64 contiguous
//     outputs with r=0..63, i=bitrev(r), idx=r; first output at E+2.
//  2. 128 continuous idata_en (two frames) -> 128 contiguous odata_en with
//     both frames in natural order and no gap at the frame boundary.
//  3. Frame with idata_en every 3rd cycle -> one 64-cycle contiguous burst
//     starting at E+2; data as in test 1.
//  4. 30 samples, reset pulse, then a full frame -> only the full frame
//     emitted, correct order; the 30 stale samples never appear.
//  5. Reset asserted at output bin 20 -> odata_en=0 on the next edge; no
//     further output until a new complete frame arrives.
//  6. 63 samples then idle for 200 cycles -> odata_en stays 0; the 64th
//     sample then triggers a full burst at E+2.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the 64-point SDF FFT: takes bit-reversed frames
// into a ping-pong buffer and replays each complete frame in natural bin order.
module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6,
    parameter int N     = 2 ** LOG_N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic [LOG_N-1:0] odata_idx
);

    typedef enum logic {IDLE, READ} state_t;

    logic [2*WIDTH-1:0] mem [2*N];

    logic [LOG_N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             pend_q, pend_d;
    logic             pbank_q, pbank_d;
    state_t           state_q, state_d;
    logic             rbank_q, rbank_d;
    logic [LOG_N-1:0] raddr_q, raddr_d;
    logic             odata_en_q, odata_en_d;
    logic [WIDTH-1:0] odata_r_q, odata_r_d;
    logic [WIDTH-1:0] odata_i_q, odata_i_d;
    logic [LOG_N-1:0] odata_idx_q, odata_idx_d;

    logic             full_evt;
    logic             last_rd;
    logic             start_rd;
    logic [2*WIDTH-1:0] rd_word;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset && idata_en) begin
            mem[{wbank_q, bitrev(wcnt_q)}] <= {idata_r, idata_i};
        end
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        pbank_d     = pbank_q;
        state_d     = state_q;
        rbank_d     = rbank_q;
        raddr_d     = raddr_q;

        full_evt = idata_en && (wcnt_q == LOG_N'(N - 1));
        if (idata_en) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (full_evt) begin
            wbank_d = ~wbank_q;
            pbank_d = wbank_q;
        end

        last_rd  = (state_q == READ) && (raddr_q == LOG_N'(N - 1));
        // A pending bank is taken either from idle or on the final read
        // address, so back-to-back frames replay without a gap cycle.
        start_rd = pend_q && ((state_q == IDLE) || last_rd);
        pend_d   = (pend_q && !start_rd) || full_evt;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = READ;
                    rbank_d = pbank_q;
                    raddr_d = '0;
                end
            end
            READ: begin
                raddr_d = raddr_q + 1'b1;
                if (last_rd) begin
                    if (pend_q) begin
                        rbank_d = pbank_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_word     = mem[{rbank_q, raddr_q}];
        odata_en_d  = (state_q == READ);
        odata_r_d   = (state_q == READ) ? rd_word[2*WIDTH-1:WIDTH] : '0;
        odata_i_d   = (state_q == READ) ? rd_word[WIDTH-1:0] : '0;
        odata_idx_d = (state_q == READ) ? raddr_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            pend_q      <= 1'b0;
            pbank_q     <= 1'b0;
            state_q     <= IDLE;
            rbank_q     <= 1'b0;
            raddr_q     <= '0;
            odata_en_q  <= 1'b0;
            odata_r_q   <= '0;
            odata_i_q   <= '0;
            odata_idx_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            pend_q      <= pend_d;
            pbank_q     <= pbank_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            raddr_q     <= raddr_d;
            odata_en_q  <= odata_en_d;
            odata_r_q   <= odata_r_d;
            odata_i_q   <= odata_i_d;
            odata_idx_q <= odata_idx_d;
        end
    end

    assign odata_en  = odata_en_q;
    assign odata_r   = odata_r_q;
    assign odata_i   = odata_i_q;
    assign odata_idx = odata_idx_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: each completed input frame queues
// its 64 natural-order outputs together with the cycle each must appear on.
module tb_fft_bitrev_reorder;

    logic        clock = 1'b0;
    logic        reset;
    logic        idata_en;
    logic [15:0] idata_r;
    logic [15:0] idata_i;
    logic        odata_en;
    logic [15:0] odata_r;
    logic [15:0] odata_i;
    logic [5:0]  odata_idx;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic [5:0]  idx;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mbuf [64];
    logic [5:0]  mcnt = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        armed = 1'b0;

    fft_bitrev_reorder #(.WIDTH(16), .LOG_N(6)) dut (
        .clock(clock), .reset(reset),
        .idata_en(idata_en), .idata_r(idata_r), .idata_i(idata_i),
        .odata_en(odata_en), .odata_r(odata_r), .odata_i(odata_i),
        .odata_idx(odata_idx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [5:0] brev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of input; the model tracks accepted samples and, on the
    // 64th, queues the frame in natural order due from E+2 onwards.
    task automatic send(input logic en, input logic [15:0] r, input logic [15:0] i);
        idata_en = en;
        idata_r  = r;
        idata_i  = i;
        @(posedge clock);
        #1;
        if (en) begin
            mbuf[brev6(mcnt)] = {r, i};
            if (mcnt == 6'd63) begin
                for (int b = 0; b < 64; b++)
                    sb.push_back('{mbuf[b][31:16], mbuf[b][15:0], 6'(b), cyc + 2 + b});
            end
            mcnt = mcnt + 1'b1;
        end
        idata_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mcnt  = '0;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic frame_t1();
        for (int k = 0; k < 64; k++) send(1'b1, 16'(brev6(6'(k))), 16'(k));
    endtask

    always @(negedge clock) begin
        if (armed) begin
            if (odata_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(odata_en), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_r", 64'(odata_r), 64'(e.r));
                    chk("out_i", 64'(odata_i), 64'(e.i));
                    chk("out_idx", 64'(odata_idx), 64'(e.idx));
                    chk("out_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("idle_zero", 64'({odata_r, odata_i, odata_idx}), 64'd0);
            end
        end
    end

    initial begin
        int n;
        reset    = 1'b1;
        idata_en = 1'b0;
        idata_r  = '0;
        idata_i  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        chk("rst_en", 64'(odata_en), 64'd0);
        chk("rst_data", 64'({odata_r, odata_i, odata_idx}), 64'd0);

        // 1: single frame with self-describing pattern
        frame_t1();
        drain("t1_drain");

        // 2: two back-to-back random frames
        for (int k = 0; k < 128; k++) send(1'b1, 16'($urandom), 16'($urandom));
        drain("t2_drain");

        // 3: sparse input, one sample every third cycle
        for (int k = 0; k < 64; k++) begin
            send(1'b1, 16'(brev6(6'(k))), 16'(k));
            send(1'b0, 16'hdead, 16'hbeef);
            send(1'b0, 16'hdead, 16'hbeef);
        end
        drain("t3_drain");

        // 4: partial frame discarded by reset
        for (int k = 0; k < 30; k++) send(1'b1, 16'hf000 + 16'(k), 16'h0f00 + 16'(k));
        do_reset();
        frame_t1();
        drain("t4_drain");

        // 5: reset during read-out at bin 20
        frame_t1();
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(odata_en && odata_idx == 6'd20) && n < 300);
        chk("t5_reach_bin20", 64'(odata_idx), 64'd20);
        do_reset();
        @(negedge clock);
        chk("t5_en_after_rst", 64'(odata_en), 64'd0);
        repeat (100) send(1'b0, '0, '0);
        for (int k = 0; k < 64; k++) send(1'b1, 16'h1234 ^ 16'(k), 16'(k * 7));
        drain("t5_recover");

        // 6: 63 samples held through a long idle, then the last one
        for (int k = 0; k < 63; k++) send(1'b1, 16'h8000 | 16'(k), 16'h4000 | 16'(k));
        repeat (200) send(1'b0, '0, '0);
        send(1'b1, 16'h803f, 16'h403f);
        drain("t6_drain");

        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
